ex_mdu: RTL and testbench

Execute stage for RV32IM, replacing the purely combinational RV32I execute stage. It covers the full RV32I integer/branch/jump set. It adds the M extension through a pipelined multiplier and an iterative divider. While a multi-cycle operation is in flight, it stalls the front end with `hold_flag_o`. It sits between the ID/EX pipeline register and the register-file write port and PC mux, with the same port set plus clock, reset and flush.

---
 rtl/ex_mdu.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ex_mdu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu.sv
// RV32IM execute stage: combinational RV32I ALU/branch unit plus a multi-cycle
// M-extension engine (staged multiplier, restoring divider) that stalls the front end.
module ex_mdu #(
    parameter int MUL_STAGES     = 2,
    parameter int DIV_RADIX_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic [31:0] ins_i,
    input  logic [31:0] ins_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wr_en,
    output logic [31:0] jump_addr_o,
    output logic        jump_en_o,
    output logic        hold_flag_o
);

    localparam int         DIV_ITERS = 32 / DIV_RADIX_LOG2;
    localparam logic [4:0] MUL_LAST  = 5'((MUL_STAGES > 1) ? (MUL_STAGES - 2) : 0);
    localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    // Instruction fields and immediates
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [4:0]  w_shamt;
    logic [31:0] w_imm_i, w_imm_b, w_imm_j, w_imm_u;

    assign w_opcode = ins_i[6:0];
    assign w_rd     = ins_i[11:7];
    assign w_f3     = ins_i[14:12];
    assign w_f7     = ins_i[31:25];
    assign w_shamt  = ins_i[24:20];
    assign w_imm_i  = {{20{ins_i[31]}}, ins_i[31:20]};
    assign w_imm_b  = {{20{ins_i[31]}}, ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
    assign w_imm_j  = {{12{ins_i[31]}}, ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
    assign w_imm_u  = {ins_i[31:12], 12'b0};

    assign ins_o      = ins_i;
    assign ins_addr_o = ins_addr_i;

    logic w_is_mop, w_is_mul;
    assign w_is_mop = (w_opcode == OPC_OP) && (w_f7 == 7'b0000001);
    assign w_is_mul = w_is_mop && !w_f3[2];

    // Base-instruction datapath
    logic        w_base_wr, w_base_jen, w_br_take;
    logic [31:0] w_base_data, w_base_jaddr;

    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_base_wr    = 1'b0;
        w_base_data  = '0;
        w_base_jen   = 1'b0;
        w_base_jaddr = '0;
        w_br_take    = 1'b0;
        case (w_opcode)
            OPC_OP_IMM: begin
                case (w_f3)
                    3'b000: begin w_base_wr = 1'b1; w_base_data = rs1_data_i + w_imm_i; end
                    3'b010: begin w_base_wr = 1'b1; w_base_data = {31'b0, $signed(rs1_data_i) < $signed(w_imm_i)}; end
                    3'b011: begin w_base_wr = 1'b1; w_base_data = {31'b0, rs1_data_i < w_imm_i}; end
                    3'b100: begin w_base_wr = 1'b1; w_base_data = rs1_data_i ^ w_imm_i; end
                    3'b110: begin w_base_wr = 1'b1; w_base_data = rs1_data_i | w_imm_i; end
                    3'b111: begin w_base_wr = 1'b1; w_base_data = rs1_data_i & w_imm_i; end
                    3'b001: if (w_f7 == 7'b0000000) begin
                        w_base_wr = 1'b1; w_base_data = rs1_data_i << w_shamt;
                    end
                    default: if (w_f7 == 7'b0000000) begin
                        w_base_wr = 1'b1; w_base_data = rs1_data_i >> w_shamt;
                    end else if (w_f7 == 7'b0100000) begin
                        w_base_wr = 1'b1; w_base_data = $signed(rs1_data_i) >>> w_shamt;
                    end
                endcase
            end
            OPC_OP: begin
                if (w_f7 == 7'b0000000) begin
                    w_base_wr = 1'b1;
                    case (w_f3)
                        3'b000:  w_base_data = rs1_data_i + rs2_data_i;
                        3'b001:  w_base_data = rs1_data_i << rs2_data_i[4:0];
                        3'b010:  w_base_data = {31'b0, $signed(rs1_data_i) < $signed(rs2_data_i)};
                        3'b011:  w_base_data = {31'b0, rs1_data_i < rs2_data_i};
                        3'b100:  w_base_data = rs1_data_i ^ rs2_data_i;
                        3'b101:  w_base_data = rs1_data_i >> rs2_data_i[4:0];
                        3'b110:  w_base_data = rs1_data_i | rs2_data_i;
                        default: w_base_data = rs1_data_i & rs2_data_i;
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_base_wr = 1'b1; w_base_data = rs1_data_i - rs2_data_i;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_base_wr = 1'b1; w_base_data = $signed(rs1_data_i) >>> rs2_data_i[4:0];
                end
            end
            OPC_LUI:   begin w_base_wr = 1'b1; w_base_data = w_imm_u; end
            OPC_AUIPC: begin w_base_wr = 1'b1; w_base_data = ins_addr_i + w_imm_u; end
            OPC_JAL: begin
                w_base_wr    = 1'b1;
                w_base_data  = ins_addr_i + 32'd4;
                w_base_jen   = 1'b1;
                w_base_jaddr = ins_addr_i + w_imm_j;
            end
            OPC_JALR: if (w_f3 == 3'b000) begin
                w_base_wr    = 1'b1;
                w_base_data  = ins_addr_i + 32'd4;
                w_base_jen   = 1'b1;
                w_base_jaddr = (rs1_data_i + w_imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                case (w_f3)
                    3'b000:  w_br_take = (rs1_data_i == rs2_data_i);
                    3'b001:  w_br_take = (rs1_data_i != rs2_data_i);
                    3'b100:  w_br_take = ($signed(rs1_data_i) <  $signed(rs2_data_i));
                    3'b101:  w_br_take = ($signed(rs1_data_i) >= $signed(rs2_data_i));
                    3'b110:  w_br_take = (rs1_data_i <  rs2_data_i);
                    3'b111:  w_br_take = (rs1_data_i >= rs2_data_i);
                    default: w_br_take = 1'b0;
                endcase
                w_base_jen   = w_br_take;
                w_base_jaddr = w_br_take ? (ins_addr_i + w_imm_b) : 32'd0;
            end
            default: ;
        endcase
    end

    // M-extension state
    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [4:0]  r_rd;
    logic        r_is_mul, r_mul_hi, r_want_rem, r_neg_q, r_neg_r;
    logic [32:0] r_mul_a, r_mul_b;
    logic [31:0] r_quot, r_rem, r_divisor, r_result;

    logic [63:0] w_prod;
    assign w_prod = {{31{r_mul_a[32]}}, r_mul_a} * {{31{r_mul_b[32]}}, r_mul_b};

    logic        w_div_signed, w_div_zero, w_div_ovf;
    logic [31:0] w_abs_a, w_abs_b, w_special;
    assign w_div_signed = !w_f3[0];
    assign w_div_zero   = (rs2_data_i == 32'd0);
    assign w_div_ovf    = w_div_signed && (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
    assign w_abs_a      = (w_div_signed && rs1_data_i[31]) ? -rs1_data_i : rs1_data_i;
    assign w_abs_b      = (w_div_signed && rs2_data_i[31]) ? -rs2_data_i : rs2_data_i;
    assign w_special    = w_div_zero ? (w_f3[1] ? rs1_data_i : 32'hFFFF_FFFF)
                                     : (w_f3[1] ? 32'd0 : 32'h8000_0000);

    // Restoring divider: DIV_RADIX_LOG2 shift/subtract steps per cycle
    logic [32:0] w_div_shift;
    logic [31:0] w_q_nxt, w_r_nxt, w_div_res;
    always_comb begin
        w_q_nxt     = r_quot;
        w_r_nxt     = r_rem;
        w_div_shift = '0;
        for (int k = 0; k < DIV_RADIX_LOG2; k++) begin
            w_div_shift = {w_r_nxt, w_q_nxt[31]};
            w_q_nxt     = {w_q_nxt[30:0], 1'b0};
            if (w_div_shift >= {1'b0, r_divisor}) begin
                w_r_nxt    = 32'(w_div_shift - {1'b0, r_divisor});
                w_q_nxt[0] = 1'b1;
            end else begin
                w_r_nxt = w_div_shift[31:0];
            end
        end
    end
    assign w_div_res = r_want_rem ? (r_neg_r ? -w_r_nxt : w_r_nxt)
                                  : (r_neg_q ? -w_q_nxt : w_q_nxt);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd       <= '0;
            r_is_mul   <= 1'b0;
            r_mul_hi   <= 1'b0;
            r_want_rem <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_result   <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_is_mop) begin
                    r_rd       <= w_rd;
                    r_cnt      <= '0;
                    r_is_mul   <= w_is_mul;
                    r_mul_hi   <= (w_f3[1:0] != 2'b00);
                    r_want_rem <= w_f3[1];
                    if (w_is_mul) begin
                        r_mul_a <= {(w_f3[1:0] != 2'b11) & rs1_data_i[31], rs1_data_i};
                        r_mul_b <= {!w_f3[1] & rs2_data_i[31], rs2_data_i};
                        r_state <= (MUL_STAGES == 1) ? S_DONE : S_MUL;
                    end else if (w_div_zero || w_div_ovf) begin
                        r_result <= w_special;
                        r_state  <= S_DONE;
                    end else begin
                        r_quot    <= w_abs_a;
                        r_rem     <= '0;
                        r_divisor <= w_abs_b;
                        r_neg_q   <= w_div_signed & (rs1_data_i[31] ^ rs2_data_i[31]);
                        r_neg_r   <= w_div_signed & rs1_data_i[31];
                        r_state   <= S_DIV;
                    end
                end
                S_MUL: begin
                    if (r_cnt == MUL_LAST) r_state <= S_DONE;
                    else                   r_cnt   <= r_cnt + 5'd1;
                end
                S_DIV: begin
                    r_quot <= w_q_nxt;
                    r_rem  <= w_r_nxt;
                    if (r_cnt == DIV_LAST) begin
                        r_result <= w_div_res;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic [31:0] w_done_data;
    assign w_done_data = r_is_mul ? (r_mul_hi ? w_prod[63:32] : w_prod[31:0]) : r_result;

    // Output steering; reset and flush override everything except the pass-throughs
    always_comb begin
        rd_addr_o   = '0;
        rd_data_o   = '0;
        rd_wr_en    = 1'b0;
        jump_addr_o = '0;
        jump_en_o   = 1'b0;
        hold_flag_o = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_DONE: if (!flush_i) begin
                    rd_wr_en  = 1'b1;
                    rd_addr_o = r_rd;
                    rd_data_o = w_done_data;
                end
                S_MUL, S_DIV: hold_flag_o = !flush_i;
                default: begin
                    if (w_is_mop) begin
                        hold_flag_o = !flush_i;
                    end else begin
                        rd_wr_en    = w_base_wr & !flush_i;
                        rd_addr_o   = w_base_wr ? w_rd : 5'd0;
                        rd_data_o   = w_base_data;
                        jump_en_o   = w_base_jen;
                        jump_addr_o = w_base_jaddr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu: base ALU/branch ops, M-ops at both
// divider radices, special cases, flush and mid-operation reset.
module tb_ex_mdu;

    logic        clk, rst_n, flush;
    logic [31:0] ins, pc, rs1, rs2;
    logic [31:0] ins_b, pc_b, rs1_b, rs2_b;

    logic [31:0] a_ins_o, a_pc_o, a_data, a_jaddr;
    logic [4:0]  a_addr;
    logic        a_wr, a_jen, a_hold;
    logic [31:0] b_ins_o, b_pc_o, b_data, b_jaddr;
    logic [4:0]  b_addr;
    logic        b_wr, b_jen, b_hold;

    int n_pass  = 0;
    int n_total = 0;

    ex_mdu u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .ins_i(ins), .ins_addr_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
        .ins_o(a_ins_o), .ins_addr_o(a_pc_o), .rd_addr_o(a_addr), .rd_data_o(a_data),
        .rd_wr_en(a_wr), .jump_addr_o(a_jaddr), .jump_en_o(a_jen), .hold_flag_o(a_hold)
    );

    ex_mdu #(.MUL_STAGES(2), .DIV_RADIX_LOG2(2)) u_dut_r2 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .ins_i(ins_b), .ins_addr_i(pc_b), .rs1_data_i(rs1_b), .rs2_data_i(rs2_b),
        .ins_o(b_ins_o), .ins_addr_o(b_pc_o), .rd_addr_o(b_addr), .rd_data_o(b_data),
        .rd_wr_en(b_wr), .jump_addr_o(b_jaddr), .jump_en_o(b_jen), .hold_flag_o(b_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, 5'd1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Apply a base instruction to the default DUT at a falling edge and let it settle.
    task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ins = i; pc = p; rs1 = a; rs2 = b;
        #1;
    endtask

    // Issue an M-op, count hold cycles until the writeback, then check the result.
    task automatic run_mop(input bit use_b, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int exp_n, input string tag);
        int   n;
        logic wr, hold;
        @(negedge clk);
        if (use_b) begin ins_b = i; rs1_b = a; rs2_b = b; end
        else       begin ins   = i; rs1   = a; rs2   = b; end
        #1;
        hold = use_b ? b_hold : a_hold;
        wr   = use_b ? b_wr   : a_wr;
        check({tag, " issue_hold"}, 32'({hold, wr}), 32'b10);
        n = 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            hold = use_b ? b_hold : a_hold;
            wr   = use_b ? b_wr   : a_wr;
            if (wr || !hold) break;
            n++;
        end
        check({tag, " wr_en"},      32'(wr), 32'd1);
        check({tag, " hold_cycles"}, 32'(n), 32'(exp_n));
        check({tag, " data"},       use_b ? b_data : a_data, exp);
        check({tag, " addr"},       32'(use_b ? b_addr : a_addr), 32'd5);
        check({tag, " done_hold"},  32'(hold), 32'd0);
        if (use_b) ins_b = '0;
        else       ins   = '0;
    endtask

    initial begin
        int wr_seen;
        rst_n = 1'b0; flush = 1'b0;
        ins = '0; pc = '0; rs1 = '0; rs2 = '0;
        ins_b = '0; pc_b = '0; rs1_b = '0; rs2_b = '0;

        // Reset forces outputs to zero even with a live instruction
        apply(enc_i(12'hFFF, 3'b000, 5'd1, 7'b0010011), 32'h40, 32'd0, 32'd0);
        check("rst wr_en",   32'(a_wr),   32'd0);
        check("rst data",    a_data,      32'd0);
        check("rst hold",    32'(a_hold), 32'd0);
        check("rst jump_en", 32'(a_jen),  32'd0);
        check("pass ins",    a_ins_o,     ins);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("addi data", a_data, 32'hFFFF_FFFF);
        check("addi wr",   32'(a_wr),   32'd1);
        check("addi addr", 32'(a_addr), 32'd1);
        check("addi hold", 32'(a_hold), 32'd0);

        apply(enc_i(12'h000, 3'b010, 5'd2, 7'b0010011), 32'h44, 32'hFFFF_FFFF, 32'd0);
        check("slti", a_data, 32'd1);
        apply(enc_i(12'h000, 3'b011, 5'd2, 7'b0010011), 32'h48, 32'hFFFF_FFFF, 32'd0);
        check("sltiu", a_data, 32'd0);
        apply(enc_i(12'h404, 3'b101, 5'd2, 7'b0010011), 32'h4C, 32'h8000_0000, 32'd0);
        check("srai", a_data, 32'hF800_0000);
        apply(enc_r(7'b0100000, 3'b000, 5'd4), 32'h50, 32'd3, 32'd5);
        check("sub", a_data, 32'hFFFF_FFFE);
        apply({20'h12345, 5'd3, 7'b0110111}, 32'h54, 32'd0, 32'd0);
        check("lui", a_data, 32'h1234_5000);
        apply(enc_i(12'h004, 3'b000, 5'd1, 7'b1100111), 32'h200, 32'h1001, 32'd0);
        check("jalr target", a_jaddr, 32'h1004);
        check("jalr link",   a_data,  32'h204);
        apply(enc_i(12'h000, 3'b010, 5'd1, 7'b0000011), 32'h58, 32'h99, 32'h77);
        check("load illegal wr",   32'(a_wr), 32'd0);
        check("load illegal data", a_data,    32'd0);

        apply(enc_b(13'h020, 3'b100), 32'h100, 32'hFFFF_FFFB, 32'd3);
        check("blt en",   32'(a_jen), 32'd1);
        check("blt addr", a_jaddr,    32'h120);
        check("blt wr",   32'(a_wr),  32'd0);
        apply(enc_b(13'h020, 3'b111), 32'h100, 32'hFFFF_FFFB, 32'd3);
        check("bgeu en",   32'(a_jen), 32'd1);
        check("bgeu addr", a_jaddr,    32'h120);
        apply(enc_b(13'h020, 3'b000), 32'h100, 32'hFFFF_FFFB, 32'd3);
        check("beq en",   32'(a_jen), 32'd0);
        check("beq addr", a_jaddr,    32'd0);

        run_mop(1'b0, enc_r(7'b0000001, 3'b001, 5'd5), 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh");
        run_mop(1'b0, enc_r(7'b0000001, 3'b010, 5'd5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu");
        run_mop(1'b0, enc_r(7'b0000001, 3'b000, 5'd5), 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul");
        run_mop(1'b0, enc_r(7'b0000001, 3'b011, 5'd5), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu");

        run_mop(1'b0, enc_r(7'b0000001, 3'b100, 5'd5), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
        run_mop(1'b0, enc_r(7'b0000001, 3'b110, 5'd5), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
        run_mop(1'b0, enc_r(7'b0000001, 3'b101, 5'd5), 32'd100,       32'd7, 32'd14,        33, "divu");
        run_mop(1'b0, enc_r(7'b0000001, 3'b111, 5'd5), 32'd100,       32'd7, 32'd2,         33, "remu");
        run_mop(1'b1, enc_r(7'b0000001, 3'b100, 5'd5), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 17, "div_r2");
        run_mop(1'b1, enc_r(7'b0000001, 3'b110, 5'd5), 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 17, "rem_r2");

        run_mop(1'b0, enc_r(7'b0000001, 3'b101, 5'd5), 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run_mop(1'b0, enc_r(7'b0000001, 3'b111, 5'd5), 32'd5,         32'd0,         32'd5,         1, "remu_by0");
        run_mop(1'b0, enc_r(7'b0000001, 3'b110, 5'd5), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");
        run_mop(1'b0, enc_r(7'b0000001, 3'b100, 5'd5), 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");

        // Flush in cycle 10 of a division: no writeback, idle afterwards
        apply(enc_r(7'b0000001, 3'b100, 5'd5), 32'h300, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush hold", 32'(a_hold), 32'd0);
        check("flush wr",   32'(a_wr),   32'd0);
        @(negedge clk);
        flush = 1'b0; ins = '0;
        #1;
        check("post-flush hold", 32'(a_hold), 32'd0);
        wr_seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (a_wr) wr_seen++;
        end
        check("post-flush no wr", 32'(wr_seen), 32'd0);

        // Reset in cycle 5 of a division, then an ADD right after release
        apply(enc_r(7'b0000001, 3'b100, 5'd5), 32'h400, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst hold", 32'(a_hold), 32'd0);
        check("midrst wr",   32'(a_wr),   32'd0);
        check("midrst data", a_data,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ins = enc_r(7'b0000000, 3'b000, 5'd7); rs1 = 32'd3; rs2 = 32'd4;
        #1;
        check("add data", a_data,      32'd7);
        check("add wr",   32'(a_wr),   32'd1);
        check("add addr", 32'(a_addr), 32'd7);
        check("add hold", 32'(a_hold), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
